// File: rtl/dmem_responder.sv
// Single-port data memory that answers RV32I loads/stores over a valid/ready
// request channel with a fixed, parameterised response latency.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t      state, next_state;
   logic [3:0]  count;
   logic        cap_we;
   logic [2:0]  cap_funct3;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        enter_resp;
   logic        op_we;
   logic [2:0]  op_funct3;
   logic [31:0] op_addr;
   logic [31:0] op_wdata;
   logic        legal_funct3;
   logic        misaligned;
   logic        out_of_range;
   logic        op_err;
   logic [AW-1:0] word_idx;
   logic [31:0] rd_word;
   logic [31:0] rd_shifted;
   logic [31:0] load_val;
   logic [3:0]  byte_en;
   logic [31:0] wr_data;

   assign accept     = req_valid && (state == IDLE);
   assign enter_resp = (state != RESP) && (next_state == RESP);

   // With LATENCY = 1 the accept edge is also the RESP entry edge, so the live
   // request must drive the datapath while the captured copy is still stale.
   assign op_we     = (state == IDLE) ? req_we     : cap_we;
   assign op_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;
   assign op_addr   = (state == IDLE) ? req_addr   : cap_addr;
   assign op_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (req_valid) next_state = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (count == 4'd1) next_state = RESP;
         RESP: if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= 4'd0;
         cap_we     <= 1'b0;
         cap_funct3 <= 3'd0;
         cap_addr   <= 32'd0;
         cap_wdata  <= 32'd0;
      end else if (accept) begin
         count      <= 4'(LATENCY - 1);
         cap_we     <= req_we;
         cap_funct3 <= req_funct3;
         cap_addr   <= req_addr;
         cap_wdata  <= req_wdata;
      end else if (state == WAIT) begin
         count <= count - 4'd1;
      end
   end

   always_comb begin
      legal_funct3 = 1'b0;
      if (op_we) legal_funct3 = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) || (op_funct3 == 3'b010);
      else       legal_funct3 = (op_funct3 == 3'b000) || (op_funct3 == 3'b001) || (op_funct3 == 3'b010)
                             || (op_funct3 == 3'b100) || (op_funct3 == 3'b101);
      misaligned   = ((op_funct3[1:0] == 2'b01) && op_addr[0])
                  || ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
      out_of_range = |op_addr[31:AW+2];
      op_err       = !legal_funct3 || misaligned || out_of_range;
      word_idx     = op_addr[AW+1:2];
   end

   // Load lane selection and extension; funct3[2] distinguishes LBU/LHU.
   always_comb begin
      rd_word    = mem[word_idx];
      rd_shifted = rd_word >> {op_addr[1:0], 3'b000};
      case (op_funct3)
         3'b000:  load_val = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
         3'b001:  load_val = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
         3'b100:  load_val = {24'd0, rd_shifted[7:0]};
         3'b101:  load_val = {16'd0, rd_shifted[15:0]};
         default: load_val = rd_shifted;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      case (op_funct3)
         3'b000: begin
            byte_en = 4'b0001 << op_addr[1:0];
            wr_data = {4{op_wdata[7:0]}};
         end
         3'b001: begin
            byte_en = op_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{op_wdata[15:0]}};
         end
         default: begin
            byte_en = 4'b1111;
            wr_data = op_wdata;
         end
      endcase
   end

   // Storage is deliberately left out of reset; rst only blocks a commit.
   always_ff @(posedge clk) begin
      if (enter_resp && op_we && !op_err && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (enter_resp) begin
         rsp_err   <= op_err;
         rsp_rdata <= (op_err || op_we) ? 32'd0 : load_val;
      end
   end

endmodule
